// File: rtl/instruction_fetch.sv
// BeeF fetch stage: walks the PC through a synchronous instruction memory and
// buffers returned words in a 2-entry FIFO presented to decode over valid/ready.
module instruction_fetch #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_rd,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  // Decoder NOP encoding (definitions::op_code), shown when the FIFO is empty.
  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(0);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   tag_pc_q, tag_pc_d;
  logic                inflight_q, inflight_d;
  logic [1:0]          count_q, count_d;
  logic [INSTR_W-1:0]  head_instr_q, head_instr_d;
  logic [ADDR_W-1:0]   head_pc_q, head_pc_d;
  logic [INSTR_W-1:0]  tail_instr_q, tail_instr_d;
  logic [ADDR_W-1:0]   tail_pc_q, tail_pc_d;

  logic                pop;
  logic                flush;
  logic                capture;
  logic                issue;
  logic [2:0]          occupancy;
  logic [1:0]          count_after_pop;

  // Handshake and credit: buffered + outstanding entries, less the one leaving now.
  always_comb begin
    pop             = out_valid & out_ready;
    flush           = redirect | stop;
    capture         = inflight_q & ~flush;
    occupancy       = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    count_after_pop = count_q - 2'(pop);
    issue           = (state_q == RUN) & ~redirect & ~stop & (occupancy < 3'd2);
  end

  // Control FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: stop takes priority over start; start in RUN is a no-op.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && !stop) state_d = RUN;
      RUN:  if (stop)           state_d = IDLE;
    endcase
  end

  // PC sequencing and in-flight tag.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_pc_d   = tag_pc_q;
    inflight_d = issue;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      tag_pc_d   = fetch_pc_q;
    end
  end

  // Shift FIFO: head is always entry 0; a capture lands behind whatever survives the pop.
  always_comb begin
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;
    count_d      = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        head_instr_d = tail_instr_q;
        head_pc_d    = tail_pc_q;
      end
      if (capture) begin
        if (count_after_pop == 2'd0) begin
          head_instr_d = imem_data;
          head_pc_d    = tag_pc_q;
        end else begin
          tail_instr_d = imem_data;
          tail_pc_d    = tag_pc_q;
        end
      end
      count_d = count_after_pop + 2'(capture);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q   <= '0;
      tag_pc_q     <= '0;
      inflight_q   <= 1'b0;
      count_q      <= 2'd0;
      head_instr_q <= NOP;
      head_pc_q    <= '0;
      tail_instr_q <= NOP;
      tail_pc_q    <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      tag_pc_q     <= tag_pc_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
    end
  end

  assign imem_rd   = issue;
  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_instr = out_valid ? head_instr_q : NOP;
  assign out_pc    = out_valid ? head_pc_q : '0;

  // Credit accounting must make a third buffered entry impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(capture && (count_after_pop == 2'd2)));

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, backpressure, redirect,
// PC wrap, stop+redirect flush and mid-stream reset, against mem[i] = i+1.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       redirect = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic       imem_rd;
  logic [7:0] imem_addr;
  logic [8:0] imem_data = 9'h000;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [8:0] out_instr;
  logic [7:0] out_pc;

  int tests_run = 0;
  int tests_failed = 0;

  instruction_fetch #(.ADDR_W(8), .INSTR_W(9)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] mem_word(input logic [7:0] a);
    return 9'(a) + 9'd1;
  endfunction

  // Synchronous instruction memory: data valid the cycle after the read.
  always @(posedge clk) begin
    if (imem_rd) imem_data <= mem_word(imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_word(input string tag, input logic [7:0] pc);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_pc"}, 32'(out_pc), 32'(pc));
    check({tag, "_instr"}, 32'(out_instr), 32'(mem_word(pc)));
  endtask

  task automatic expect_reset(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_rd"}, 32'(imem_rd), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_instr"}, 32'(out_instr), 32'd0);
    check({tag, "_pc"}, 32'(out_pc), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    expect_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_rd", 32'(imem_rd), 32'd0);

    // Start: first read next cycle, valid two cycles after that.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_rd", 32'(imem_rd), 32'd1);
    check("first_addr", 32'(imem_addr), 32'd0);
    check("lat0_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat1_valid", 32'(out_valid), 32'd0);
    check("lat1_addr", 32'(imem_addr), 32'd1);
    @(negedge clk);
    expect_word("s0", 8'd0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      expect_word($sformatf("s%0d", k), 8'(k));
    end
    check("steady_addr", 32'(imem_addr), 32'd9);

    // Backpressure for 5 cycles: output held, reads stop once 2 are buffered.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      expect_word($sformatf("bp%0d", k), 8'd7);
      check($sformatf("bp%0d_rd", k), 32'(imem_rd), 32'd0);
    end
    out_ready = 1'b1;
    for (int k = 8; k <= 11; k++) begin
      @(negedge clk);
      expect_word($sformatf("rel%0d", k), 8'(k));
    end

    // Redirect to 0, then redirect to 0x40 while pc 0x05 is in flight.
    redirect = 1'b1;
    redirect_pc = 8'h00;
    @(negedge clk);
    redirect = 1'b0;
    check("r0_v1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("r0_v2", 32'(out_valid), 32'd0);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      expect_word($sformatf("r0_%0d", k), 8'(k));
    end
    redirect = 1'b1;
    redirect_pc = 8'h40;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("r40_v1", 32'(out_valid), 32'd0);
    check("r40_rd", 32'(imem_rd), 32'd1);
    check("r40_addr", 32'(imem_addr), 32'h40);
    @(negedge clk);
    check("r40_v2", 32'(out_valid), 32'd0);
    @(negedge clk);
    expect_word("r40_a", 8'h40);
    @(negedge clk);
    expect_word("r40_b", 8'h41);

    // PC wrap from 0xFE.
    redirect = 1'b1;
    redirect_pc = 8'hFE;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expect_word("wrap_fe", 8'hFE);
    @(negedge clk);
    expect_word("wrap_ff", 8'hFF);
    @(negedge clk);
    expect_word("wrap_00", 8'h00);
    @(negedge clk);
    expect_word("wrap_01", 8'h01);

    // Fill FIFO, then stop together with redirect to 0x10.
    out_ready = 1'b0;
    @(negedge clk);
    expect_word("full", 8'h01);
    check("full_rd", 32'(imem_rd), 32'd0);
    stop = 1'b1;
    redirect = 1'b1;
    redirect_pc = 8'h10;
    @(negedge clk);
    stop = 1'b0;
    redirect = 1'b0;
    #1;
    check("sr_valid", 32'(out_valid), 32'd0);
    check("sr_rd", 32'(imem_rd), 32'd0);
    check("sr_addr", 32'(imem_addr), 32'h10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("sr_idle%0d_rd", k), 32'(imem_rd), 32'd0);
      check($sformatf("sr_idle%0d_v", k), 32'(out_valid), 32'd0);
    end
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("sr_start_rd", 32'(imem_rd), 32'd1);
    check("sr_start_addr", 32'(imem_addr), 32'h10);
    @(negedge clk);
    @(negedge clk);
    expect_word("sr_first", 8'h10);
    @(negedge clk);
    expect_word("sr_second", 8'h11);

    // Reset asserted mid-stream with two entries buffered.
    out_ready = 1'b0;
    @(negedge clk);
    expect_word("pre_rst", 8'h11);
    rst_n = 1'b0;
    #1;
    expect_reset("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d_v", k), 32'(out_valid), 32'd0);
      check($sformatf("post_rst%0d_rd", k), 32'(imem_rd), 32'd0);
    end

    // start together with stop: stop wins, stays idle.
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    #1;
    check("start_stop_rd", 32'(imem_rd), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_rd", 32'(imem_rd), 32'd1);
    check("restart_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    expect_word("restart_first", 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
